// File: rtl/seq_detect_param.sv
// Serial pattern detector: programmable PAT_LEN-bit pattern with overlap and lock-on-match modes,
// plus a saturating match counter.
module seq_detect_param #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               cfg_lock,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               match,
   output logic               locked,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   localparam int FW = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_ARMED,
      S_LOCKED
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               accept;
   logic [PAT_LEN-1:0] hist_shift;
   logic [FW-1:0]      fill_inc;
   logic               hit;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q <= S_IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         count_q <= count_d;
      end
   end

   // The hit is judged on the post-shift history and live cfg_pattern.
   always_comb begin
      accept     = in_valid && (state_q != S_LOCKED);
      hist_shift = {hist_q[PAT_LEN-2:0], in_bit};
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
      hit        = accept && (fill_inc == FILL_FULL) && (hist_shift == cfg_pattern);
   end

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      count_d = count_q;

      if (accept) begin
         hist_d  = hist_shift;
         fill_d  = fill_inc;
         state_d = (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
      end

      if (hit) begin
         match_d = 1'b1;
         if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
         end
         if (cfg_lock) begin
            state_d = S_LOCKED;
         end else if (!cfg_overlap) begin
            state_d = S_IDLE;
            hist_d  = '0;
            fill_d  = '0;
         end
      end
   end

   assign match       = match_q;
   assign locked      = (state_q == S_LOCKED);
   assign match_count = count_q;
   assign count_sat   = (count_q == CNT_MAX);

endmodule
